// File: rtl/tx_gearbox_scheduler.sv
// Feeds a 66b->64b TX gearbox: schedules 66-bit blocks into 32-bit halves against
// the 0..65 gearbox sequence, stalls during the two pause slots and fills underruns with idles.
module tx_gearbox_scheduler #(
    parameter logic [63:0] P_IDLE_DATA   = 64'h1E00_0000_0000_0000,
    parameter logic [1:0]  P_IDLE_HEAD   = 2'b10,
    parameter int          P_SEQ_MAX     = 65,
    parameter int          P_PAUSE_START = 64,
    parameter int          P_CNT_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [63:0]            blk_data_i,
    input  logic [1:0]             blk_head_i,
    output logic [31:0]            data_o,
    output logic [1:0]             head_o,
    output logic [6:0]             sequence_o,
    output logic                   underrun_o,
    output logic [P_CNT_WIDTH-1:0] underrun_cnt_o
);

    localparam logic [6:0] SEQ_MAX     = 7'(P_SEQ_MAX);
    localparam logic [6:0] PAUSE_START = 7'(P_PAUSE_START);

    logic [6:0]  r_slot;
    logic        buf_valid;
    logic [63:0] buf_data;
    logic [1:0]  buf_head;
    logic [31:0] r_low;

    logic in_payload;
    logic consume;
    logic write;

    // Handshake: a block transfers on the rising clk edge where blk_valid_i & blk_ready_o;
    // ready is combinational so a block can refill the buffer in the same cycle it is drained.
    assign in_payload  = (r_slot < PAUSE_START);
    assign consume     = enable_i & in_payload & ~r_slot[0];
    assign blk_ready_o = enable_i & (~buf_valid | consume);
    assign write       = blk_valid_i & blk_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_slot         <= '0;
            buf_valid      <= 1'b0;
            buf_data       <= '0;
            buf_head       <= '0;
            r_low          <= '0;
            data_o         <= '0;
            head_o         <= '0;
            sequence_o     <= '0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else if (!enable_i) begin
            // Halt flushes everything but the underrun statistic.
            r_slot     <= '0;
            buf_valid  <= 1'b0;
            r_low      <= '0;
            data_o     <= '0;
            head_o     <= '0;
            sequence_o <= '0;
            underrun_o <= 1'b0;
        end else begin
            r_slot     <= (r_slot == SEQ_MAX) ? 7'd0 : r_slot + 7'd1;
            sequence_o <= r_slot;
            underrun_o <= 1'b0;

            if (consume) begin
                if (buf_valid) begin
                    data_o <= buf_data[63:32];
                    head_o <= buf_head;
                    r_low  <= buf_data[31:0];
                end else begin
                    data_o     <= P_IDLE_DATA[63:32];
                    head_o     <= P_IDLE_HEAD;
                    r_low      <= P_IDLE_DATA[31:0];
                    underrun_o <= 1'b1;
                    if (underrun_cnt_o != '1) begin
                        underrun_cnt_o <= underrun_cnt_o + 1'b1;
                    end
                end
            end else if (in_payload) begin
                data_o <= r_low;
            end else begin
                data_o <= '0;
            end

            // A write in a consume cycle reloads the entry, so it stays valid.
            if (write) begin
                buf_valid <= 1'b1;
                buf_data  <= blk_data_i;
                buf_head  <= blk_head_i;
            end else if (consume) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_gearbox_scheduler.sv
// Directed bench for tx_gearbox_scheduler: sequencing, pauses, underrun idles,
// enable halt and asynchronous reset, plus a random-valid scoreboard run.
module tb_tx_gearbox_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [63:0] blk_data = '0;
    logic [1:0]  blk_head = '0;
    logic [31:0] data_o;
    logic [1:0]  head_o;
    logic [6:0]  sequence_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt;

    int n_vec = 0;
    int n_err = 0;
    int slot = 0;
    int out_seq = 0;
    int pop_cnt = 0;
    logic [31:0] pend = '0;
    logic [65:0] exp_q[$];

    tx_gearbox_scheduler dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .blk_valid_i    (blk_valid),
        .blk_ready_o    (blk_ready),
        .blk_data_i     (blk_data),
        .blk_head_i     (blk_head),
        .data_o         (data_o),
        .head_o         (head_o),
        .sequence_o     (sequence_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic v, input logic [63:0] d, input logic [1:0] h);
        enable    = en;
        blk_valid = v;
        blk_data  = d;
        blk_head  = h;
        #1;
    endtask

    // One clock: records the handshake, then lands on the next negedge for sampling.
    task automatic step(output logic fire);
        fire = blk_valid & blk_ready;
        if (fire) exp_q.push_back({blk_head, blk_data});
        @(posedge clk);
        @(negedge clk);
        out_seq = enable ? slot : 0;
        if (!enable) slot = 0;
        else slot = (slot == 65) ? 0 : slot + 1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 64'd0, 2'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        slot = 0;
        exp_q.delete();
    endtask

    task automatic sb_check();
        logic [65:0] b;
        check("e_seq", 64'(sequence_o), 64'(out_seq));
        if (out_seq >= 64) begin
            check("e_pause", 64'(data_o), 64'd0);
            check("e_und_pause", 64'(underrun_o), 64'd0);
        end else if (out_seq % 2 == 0) begin
            if (underrun_o) begin
                check("e_idle_hi", 64'(data_o), 64'h1E000000);
                check("e_idle_head", 64'(head_o), 64'd2);
                pend = 32'h0;
            end else if (exp_q.size() == 0) begin
                check("e_sb_nonempty", 64'(exp_q.size()), 64'd1);
            end else begin
                b = exp_q.pop_front();
                pop_cnt++;
                check("e_hi", 64'(data_o), 64'(b[63:32]));
                check("e_head", 64'(head_o), 64'(b[65:64]));
                pend = b[31:0];
            end
        end else begin
            check("e_lo", 64'(data_o), 64'(pend));
            check("e_und_odd", 64'(underrun_o), 64'd0);
        end
    endtask

    initial begin
        logic fire;
        int n;
        int s;
        int k;
        int acc;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_data", 64'(data_o), 64'd0);
        check("rst_head", 64'(head_o), 64'd0);
        check("rst_seq", 64'(sequence_o), 64'd0);
        check("rst_und", 64'(underrun_o), 64'd0);
        check("rst_cnt", 64'(underrun_cnt), 64'd0);
        check("rst_ready", 64'(blk_ready), 64'd0);
        rst_n = 1'b1;
        slot = 0;

        // Continuous incrementing source: only the very first slot underruns
        n = 0;
        for (int c = 0; c < 132; c++) begin
            drive(1'b1, 1'b1, {32'(n), 32'(n)}, 2'b01);
            s = c % 66;
            check("b_ready", 64'(blk_ready), 64'((s % 2 == 0) && (s < 64)));
            step(fire);
            if (fire) n++;
            check("b_seq", 64'(sequence_o), 64'(s));
            check("b_und", 64'(underrun_o), 64'(c == 0));
            if (s >= 64) begin
                check("b_pause", 64'(data_o), 64'd0);
                check("b_pause_head", 64'(head_o), 64'd1);
            end else begin
                k = 32 * (c / 66) + s / 2 - 1;
                if (k < 0) begin
                    check("b_idle", 64'(data_o), (s % 2 == 0) ? 64'h1E000000 : 64'd0);
                    check("b_idle_head", 64'(head_o), 64'd2);
                end else begin
                    check("b_data", 64'(data_o), 64'(32'(k)));
                    check("b_head", 64'(head_o), 64'd1);
                end
            end
        end
        check("b_accepted", 64'(n), 64'd64);
        check("b_cnt", 64'(underrun_cnt), 64'd1);

        // No source at all: idle on every block slot
        do_reset();
        for (int c = 0; c < 66; c++) begin
            drive(1'b1, 1'b0, 64'd0, 2'd0);
            check("c_ready", 64'(blk_ready), 64'd1);
            step(fire);
            check("c_seq", 64'(sequence_o), 64'(c));
            check("c_head", 64'(head_o), 64'd2);
            check("c_und", 64'(underrun_o), 64'((c % 2 == 0) && (c < 64)));
            check("c_data", 64'(data_o), ((c % 2 == 0) && (c < 64)) ? 64'h1E000000 : 64'd0);
        end
        check("c_cnt", 64'(underrun_cnt), 64'd32);

        // Single block offered at slot 63, held across the pause
        for (int c = 0; c < 63; c++) begin
            drive(1'b1, 1'b0, 64'd0, 2'd0);
            step(fire);
        end
        check("d_cnt_before", 64'(underrun_cnt), 64'd64);
        drive(1'b1, 1'b1, 64'h0123456789ABCDEF, 2'b01);
        check("d_ready63", 64'(blk_ready), 64'd1);
        step(fire);
        check("d_seq63", 64'(sequence_o), 64'd63);
        drive(1'b1, 1'b0, 64'd0, 2'd0);
        check("d_ready64", 64'(blk_ready), 64'd0);
        step(fire);
        check("d_seq64", 64'(sequence_o), 64'd64);
        check("d_data64", 64'(data_o), 64'd0);
        check("d_ready65", 64'(blk_ready), 64'd0);
        step(fire);
        check("d_seq65", 64'(sequence_o), 64'd65);
        check("d_ready0", 64'(blk_ready), 64'd1);
        step(fire);
        check("d_seq0", 64'(sequence_o), 64'd0);
        check("d_hi", 64'(data_o), 64'h01234567);
        check("d_head", 64'(head_o), 64'd1);
        check("d_und0", 64'(underrun_o), 64'd0);
        step(fire);
        check("d_lo", 64'(data_o), 64'h89ABCDEF);
        step(fire);
        check("d_seq2", 64'(sequence_o), 64'd2);
        check("d_idle", 64'(data_o), 64'h1E000000);
        check("d_idle_head", 64'(head_o), 64'd2);
        check("d_und2", 64'(underrun_o), 64'd1);
        check("d_cnt_after", 64'(underrun_cnt), 64'd65);

        // Random valid against a scoreboard
        exp_q.delete();
        pend = 32'h0;
        acc = 0;
        pop_cnt = 0;
        for (int i = 0; i < 66000; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            step(fire);
            if (fire) acc++;
            sb_check();
        end
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, 1'b0, 64'd0, 2'd0);
            step(fire);
            sb_check();
        end
        check("e_drained", 64'(exp_q.size()), 64'd0);
        check("e_acc_vs_pop", 64'(pop_cnt), 64'(acc));

        // Halt at slot 31 for five cycles
        do_reset();
        n = 0;
        for (int c = 0; c < 31; c++) begin
            drive(1'b1, 1'b1, {32'(n), 32'(n)}, 2'b01);
            step(fire);
            if (fire) n++;
        end
        check("f_seq30", 64'(sequence_o), 64'd30);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, {32'(n), 32'(n)}, 2'b01);
            check("f_ready_off", 64'(blk_ready), 64'd0);
            step(fire);
            check("f_data_off", 64'(data_o), 64'd0);
            check("f_head_off", 64'(head_o), 64'd0);
            check("f_seq_off", 64'(sequence_o), 64'd0);
            check("f_und_off", 64'(underrun_o), 64'd0);
            check("f_cnt_off", 64'(underrun_cnt), 64'd1);
        end
        drive(1'b1, 1'b0, 64'd0, 2'd0);
        check("f_ready_on", 64'(blk_ready), 64'd1);
        step(fire);
        check("f_seq_on", 64'(sequence_o), 64'd0);
        check("f_und_on", 64'(underrun_o), 64'd1);
        check("f_data_on", 64'(data_o), 64'h1E000000);
        check("f_cnt_on", 64'(underrun_cnt), 64'd2);

        // Asynchronous reset in the middle of a block
        n = 100;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b1, {32'(n), 32'(n)}, 2'b01);
            step(fire);
            if (fire) n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("g_data", 64'(data_o), 64'd0);
        check("g_head", 64'(head_o), 64'd0);
        check("g_seq", 64'(sequence_o), 64'd0);
        check("g_und", 64'(underrun_o), 64'd0);
        check("g_cnt", 64'(underrun_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        slot = 0;
        #1;
        check("g_cnt_rel", 64'(underrun_cnt), 64'd0);
        drive(1'b1, 1'b1, {32'(n), 32'(n)}, 2'b01);
        step(fire);
        check("g_seq_rel", 64'(sequence_o), 64'd0);
        check("g_und_rel", 64'(underrun_o), 64'd1);
        check("g_cnt_first", 64'(underrun_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
